// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART with baud generator, 16x-oversampled RX/TX engines and
// circular RX/TX FIFOs exposed through valid/ready handshakes.
//   clk_100MHz, reset     : system clock, synchronous active-high reset
//   baud_div              : clocks per oversampling tick (0/1 = every cycle)
//   rx / tx               : serial line in (async) / out, idle high
//   tx_data/valid/ready   : TX FIFO push port (ready = not full)
//   rx_data/valid/ready   : RX FIFO first-word-fall-through pop port
//   tx_level, rx_level    : FIFO occupancies
//   tx_busy               : TX engine mid-frame
//   frame_err, parity_err, overrun : sticky line errors, cleared by err_clear
module uart_fifo_core #(
    parameter int DBITS           = 8,
    parameter int SB_TICK         = 16,
    parameter int DIV_BITS        = 16,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic [DIV_BITS-1:0]        baud_div,
    input  logic                       rx,
    output logic                       tx,
    input  logic [DBITS-1:0]           tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [DBITS-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [FIFO_DEPTH_LOG2:0]   tx_level,
    output logic [FIFO_DEPTH_LOG2:0]   rx_level,
    output logic                       tx_busy,
    output logic                       frame_err,
    output logic                       parity_err,
    output logic                       overrun,
    input  logic                       err_clear
);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam int LW = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- baud tick ----------------
    logic [DIV_BITS-1:0] baud_cnt_q;
    logic                tick;
    assign tick = (baud_div < DIV_BITS'(2)) || (baud_cnt_q == baud_div - DIV_BITS'(1));

    always_ff @(posedge clk_100MHz) begin
        if (reset || tick || baud_cnt_q >= baud_div) baud_cnt_q <= '0;
        else                                         baud_cnt_q <= baud_cnt_q + DIV_BITS'(1);
    end

    // ---------------- rx synchroniser ----------------
    logic rx_meta_q, rx_sync_q;
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ---------------- RX engine ----------------
    state_t           rx_state_q, rx_state_d;
    logic [5:0]       rx_s_q, rx_s_d;
    logic [3:0]       rx_n_q, rx_n_d;
    logic [DBITS-1:0] rx_sh_q, rx_sh_d;
    logic             rx_par_q, rx_par_d;
    logic             frame_evt, par_evt, push_evt;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        frame_evt  = 1'b0;
        par_evt    = 1'b0;
        push_evt   = 1'b0;
        case (rx_state_q)
            S_IDLE: if (!rx_sync_q) begin
                rx_state_d = S_START;
                rx_s_d     = '0;
            end
            S_START: if (tick) begin
                if (rx_s_q == 6'd7) begin
                    // line back high at mid start bit: treat as a glitch
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                    rx_s_d     = '0;
                    rx_n_d     = '0;
                end else rx_s_d = rx_s_q + 6'd1;
            end
            S_DATA: if (tick) begin
                if (rx_s_q == 6'd15) begin
                    rx_s_d  = '0;
                    rx_sh_d = {rx_sync_q, rx_sh_q[DBITS-1:1]};
                    if (rx_n_q == 4'(DBITS-1)) rx_state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                    else                       rx_n_d = rx_n_q + 4'd1;
                end else rx_s_d = rx_s_q + 6'd1;
            end
            S_PAR: if (tick) begin
                if (rx_s_q == 6'd15) begin
                    rx_s_d     = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = S_STOP;
                end else rx_s_d = rx_s_q + 6'd1;
            end
            S_STOP: if (tick) begin
                if (rx_s_q == 6'(SB_TICK-1)) begin
                    rx_state_d = S_IDLE;
                    if (!rx_sync_q) frame_evt = 1'b1;
                    else if ((PARITY_EN != 0) && (rx_par_q != ((^rx_sh_q) ^ ODD))) par_evt = 1'b1;
                    else push_evt = 1'b1;
                end else rx_s_d = rx_s_q + 6'd1;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DBITS-1:0] rx_mem [DEPTH];
    logic [AW-1:0]    rx_wp_q, rx_rp_q;
    logic [LW-1:0]    rx_lvl_q;
    logic             rx_full, rx_wr, rx_pop;

    assign rx_full  = (rx_lvl_q == LW'(DEPTH));
    assign rx_valid = (rx_lvl_q != '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_wr    = push_evt && !rx_full;
    assign rx_data  = rx_valid ? rx_mem[rx_rp_q] : '0;
    assign rx_level = rx_lvl_q;

    always_ff @(posedge clk_100MHz) begin
        if (rx_wr) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_lvl_q <= '0;
        end else begin
            if (rx_wr)  rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
            case ({rx_wr, rx_pop})
                2'b10:   rx_lvl_q <= rx_lvl_q + LW'(1);
                2'b01:   rx_lvl_q <= rx_lvl_q - LW'(1);
                default: rx_lvl_q <= rx_lvl_q;
            endcase
        end
    end

    // ---------------- sticky errors (set wins over clear) ----------------
    logic frame_err_q, parity_err_q, overrun_q;
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= frame_evt | (frame_err_q & ~err_clear);
            parity_err_q <= par_evt   | (parity_err_q & ~err_clear);
            overrun_q    <= (push_evt & rx_full) | (overrun_q & ~err_clear);
        end
    end
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    // ---------------- TX FIFO ----------------
    logic [DBITS-1:0] tx_mem [DEPTH];
    logic [AW-1:0]    tx_wp_q, tx_rp_q;
    logic [LW-1:0]    tx_lvl_q;
    logic             tx_push, tx_pop;

    assign tx_ready = !reset && (tx_lvl_q != LW'(DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    assign tx_level = tx_lvl_q;

    always_ff @(posedge clk_100MHz) begin
        if (tx_push) tx_mem[tx_wp_q] <= tx_data;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_lvl_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_lvl_q <= tx_lvl_q + LW'(1);
                2'b01:   tx_lvl_q <= tx_lvl_q - LW'(1);
                default: tx_lvl_q <= tx_lvl_q;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    state_t           tx_state_q, tx_state_d;
    logic [5:0]       tx_s_q, tx_s_d;
    logic [3:0]       tx_n_q, tx_n_d;
    logic [DBITS-1:0] tx_sh_q, tx_sh_d;
    logic             tx_par_q, tx_par_d;
    logic             tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: if (tx_lvl_q != '0) begin
                tx_pop     = 1'b1;
                tx_sh_d    = tx_mem[tx_rp_q];
                tx_par_d   = (^tx_mem[tx_rp_q]) ^ ODD;
                tx_state_d = S_START;
                tx_s_d     = '0;
            end
            S_START: if (tick) begin
                if (tx_s_q == 6'd15) begin
                    tx_s_d     = '0;
                    tx_n_d     = '0;
                    tx_state_d = S_DATA;
                end else tx_s_d = tx_s_q + 6'd1;
            end
            S_DATA: if (tick) begin
                if (tx_s_q == 6'd15) begin
                    tx_s_d  = '0;
                    tx_sh_d = tx_sh_q >> 1;
                    if (tx_n_q == 4'(DBITS-1)) tx_state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                    else                       tx_n_d = tx_n_q + 4'd1;
                end else tx_s_d = tx_s_q + 6'd1;
            end
            S_PAR: if (tick) begin
                if (tx_s_q == 6'd15) begin
                    tx_s_d     = '0;
                    tx_state_d = S_STOP;
                end else tx_s_d = tx_s_q + 6'd1;
            end
            S_STOP: if (tick) begin
                if (tx_s_q == 6'(SB_TICK-1)) tx_state_d = S_IDLE;
                else                         tx_s_d = tx_s_q + 6'd1;
            end
            default: tx_state_d = S_IDLE;
        endcase
        // line level derived from next state so the pin is a clean register
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_sh_d[0];
            S_PAR:   tx_d = tx_par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != S_IDLE);
endmodule

// File: tb/tb_uart_fifo_core.sv
module tb_uart_fifo_core;
    localparam int BIT = 64; // baud_div 4 x 16 ticks

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic       loop = 1'b0, sel2 = 1'b0, brx = 1'b1;
    logic       rx1, tx1, rx2, tx2;
    logic [7:0] tx_data = '0, rx_data, rx_data2;
    logic [7:0] tx_data2 = '0;
    logic       tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
    logic [4:0] tx_level, rx_level, tx_level2, rx_level2;
    logic       tx_busy, frame_err, parity_err, overrun, err_clear = 1'b0;
    logic       tx_valid2 = 1'b0, tx_ready2, rx_valid2, rx_ready2 = 1'b0;
    logic       tx_busy2, fe2, pe2, ov2, err_clear2 = 1'b0;

    int unsigned n_vec = 0, n_miss = 0;
    logic [7:0]  exp_q[$];

    assign rx1 = loop ? tx1 : (sel2 ? 1'b1 : brx);
    assign rx2 = sel2 ? brx : 1'b1;

    always #5 clk = ~clk;

    uart_fifo_core dut (
        .clk_100MHz(clk), .reset(reset), .baud_div(baud_div), .rx(rx1), .tx(tx1),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level), .tx_busy(tx_busy),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
        .err_clear(err_clear)
    );

    uart_fifo_core #(.PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .clk_100MHz(clk), .reset(reset), .baud_div(baud_div), .rx(rx2), .tx(tx2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
        .tx_level(tx_level2), .rx_level(rx_level2), .tx_busy(tx_busy2),
        .frame_err(fe2), .parity_err(pe2), .overrun(ov2),
        .err_clear(err_clear2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every accepted RX byte is compared against the scoreboard head
    always @(negedge clk) begin
        if (!reset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
            else                   check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic set_rx_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
        @(negedge clk);
    endtask

    // called at a negedge; holds valid for one edge
    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        brx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par, input bit stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par);
        if (stop_ok) drive_bit(1'b1);
        else begin
            brx = 1'b0;
            repeat (40) @(negedge clk);
            brx = 1'b1;
            repeat (BIT - 40) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin
        logic [9:0] frame_bits;
        int         acc;

        // ---- reset state ----
        repeat (4) @(negedge clk);
        check("rst_tx", tx1, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_levels", {tx_level, rx_level}, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_flags", {frame_err, parity_err, overrun}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_tx_ready", tx_ready, 1);

        // ---- loopback A5, 3C ----
        loop = 1'b1;
        set_rx_ready(1'b1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        push(8'hA5);
        push(8'h3C);
        for (int i = 0; i < 100 && tx1; i++) @(negedge clk);
        check("lb_start_seen", tx1, 0);
        frame_bits = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 32 : BIT) @(negedge clk);
            check($sformatf("lb_bit%0d", i), tx1, frame_bits[i]);
        end
        repeat (100) @(negedge clk);
        for (int i = 0; i < 2000 && tx_busy; i++) @(negedge clk);
        check("lb_busy_fall", tx_busy, 0);
        check("lb_tx_level", tx_level, 0);
        wait_drain("lb_drain", 200);
        check("lb_flags", {frame_err, parity_err, overrun}, 0);
        loop = 1'b0;

        // ---- frame error then recovery ----
        repeat (BIT) @(negedge clk);
        send_frame(8'h55, 0, 0, 0);
        repeat (2 * BIT) @(negedge clk);
        check("fe_set", frame_err, 1);
        check("fe_no_byte", rx_valid, 0);
        pulse_clear();
        check("fe_cleared", frame_err, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 0, 0, 1);
        wait_drain("fe_good_byte", 200);
        check("fe_after_good", frame_err, 0);

        // ---- overrun ----
        set_rx_ready(1'b0);
        for (int b = 0; b < 17; b++) send_frame(8'(b), 0, 0, 1);
        repeat (BIT) @(negedge clk);
        check("ov_level", rx_level, 16);
        check("ov_flag", overrun, 1);
        for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
        set_rx_ready(1'b1);
        wait_drain("ov_drain", 200);
        check("ov_level_empty", rx_level, 0);
        pulse_clear();
        check("ov_cleared", overrun, 0);

        // ---- parity (even) on the parity-enabled instance ----
        sel2 = 1'b1;
        send_frame(8'h01, 1, 0, 1);
        repeat (BIT) @(negedge clk);
        check("par_err_set", pe2, 1);
        check("par_no_byte", rx_valid2, 0);
        send_frame(8'h01, 1, 1, 1);
        repeat (BIT) @(negedge clk);
        check("par_good_valid", rx_valid2, 1);
        check("par_good_data", rx_data2, 8'h01);
        check("par_other_flags", {fe2, ov2}, 0);
        sel2 = 1'b0;

        // ---- glitch reject ----
        brx = 1'b0;
        repeat (12) @(negedge clk);
        brx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        check("gl_no_byte", rx_level, 0);
        check("gl_no_err", {frame_err, parity_err, overrun}, 0);

        // ---- TX FIFO full ----
        acc = 0;
        tx_valid = 1'b1;
        for (int k = 0; k < 40 && tx_level != 5'd16; k++) begin
            tx_data = 8'(8'h40 + k);
            if (tx_ready) acc++;
            @(negedge clk);
        end
        check("full_level", tx_level, 16);
        check("full_ready", tx_ready, 0);
        check("full_accepted", acc, 17);
        tx_data = 8'hEE;
        @(negedge clk);
        tx_valid = 1'b0;
        check("full_no_17th", tx_level, 16);

        // ---- reset mid-frame ----
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 6; b++) push(8'(8'h10 + b));
        for (int i = 0; i < 100 && tx1; i++) @(negedge clk);
        check("rm_start_seen", tx1, 0);
        repeat (4 * BIT + 32) @(negedge clk);
        check("rm_busy_before", tx_busy, 1);
        check("rm_level_before", tx_level, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rm_tx_high", tx1, 1);
        check("rm_level", tx_level, 0);
        check("rm_busy", tx_busy, 0);
        loop = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h7E);
        push(8'h7E);
        wait_drain("rm_7e", 2000);
        check("rm_flags", {frame_err, parity_err, overrun}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
